// File: rtl/idex_pkg.sv
// Shared types and default widths for the ID->EXE stage buffer.
package idex_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned ALUCTR_W = 3;
    localparam int unsigned OP_W     = 6;

    localparam logic [OP_W-1:0] LOAD_OP = 6'b100011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } idex_state_t;

    typedef struct packed {
        logic                mem_wr;
        logic                mem_to_reg;
        logic                reg_wr;
        logic                ext_op;
        logic                alu_src;
        logic [ALUCTR_W-1:0] alu_ctr;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rw;
        logic [DATA_W-1:0]   bus_a;
        logic [DATA_W-1:0]   bus_b;
        logic [IMM_W-1:0]    imm;
        logic                mem_read;
    } idex_entry_t;

    // True when a held load writes a non-zero register read by the incoming instruction.
    function automatic logic load_dep(input idex_entry_t e,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt);
        return e.mem_read && (e.rw != '0) && ((e.rw == rs) || (e.rw == rt));
    endfunction

endpackage

// File: rtl/idex_hazard_chk.sv
// Load-use compare of the incoming source registers against both held slots.
module idex_hazard_chk
    import idex_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [1:0]       slot_valid,
    input  idex_entry_t      main_slot,
    input  idex_entry_t      skid_slot,
    output logic             hazard_c
);

    // Stall only for a presented instruction that depends on a live load.
    always_comb begin
        hazard_c = 1'b0;
        if (id_valid) begin
            hazard_c = (slot_valid[0] && load_dep(main_slot, id_rs, id_rt)) ||
                       (slot_valid[1] && load_dep(skid_slot, id_rs, id_rt));
        end
    end

endmodule

// File: rtl/idex_stage_buf.sv
// ID->EXE stage buffer: valid/ready handshake, two-entry skid buffer, flush,
// optional load-use hazard detection (enabled by defining IDEX_HAZARD_DET_EN).
module idex_stage_buf #(
    parameter int unsigned DATA_W   = idex_pkg::DATA_W,
    parameter int unsigned REG_W    = idex_pkg::REG_W,
    parameter int unsigned IMM_W    = idex_pkg::IMM_W,
    parameter int unsigned ALUCTR_W = idex_pkg::ALUCTR_W,
    parameter int unsigned OP_W     = idex_pkg::OP_W,
    parameter logic [OP_W-1:0] LOAD_OP = idex_pkg::LOAD_OP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic                id_flush,
    input  logic                id_mem_wr,
    input  logic                id_mem_to_reg,
    input  logic                id_reg_wr,
    input  logic                id_ext_op,
    input  logic                id_alu_src,
    input  logic [ALUCTR_W-1:0] id_alu_ctr,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [REG_W-1:0]    id_rw,
    input  logic [DATA_W-1:0]   id_bus_a,
    input  logic [DATA_W-1:0]   id_bus_b,
    input  logic [IMM_W-1:0]    id_imm,
    input  logic [OP_W-1:0]     id_op,
    output logic                exe_valid,
    input  logic                exe_ready,
    output logic                exe_mem_wr,
    output logic                exe_mem_to_reg,
    output logic                exe_reg_wr,
    output logic                exe_ext_op,
    output logic                exe_alu_src,
    output logic [ALUCTR_W-1:0] exe_alu_ctr,
    output logic [REG_W-1:0]    exe_rs,
    output logic [REG_W-1:0]    exe_rt,
    output logic [REG_W-1:0]    exe_rd,
    output logic [REG_W-1:0]    exe_rw,
    output logic [DATA_W-1:0]   exe_bus_a,
    output logic [DATA_W-1:0]   exe_bus_b,
    output logic [IMM_W-1:0]    exe_imm,
    output logic                exe_mem_read,
    output logic                hazard_stall
);

    import idex_pkg::*;

    idex_state_t state_q, state_nx;
    idex_entry_t main_q, main_nx;
    idex_entry_t skid_q, skid_nx;
    idex_entry_t in_entry;
    logic        accept_c;
    logic        drain_c;

    // Pack the decode fields into one entry; mem_read is derived at capture.
    always_comb begin
        in_entry            = '0;
        in_entry.mem_wr     = id_mem_wr;
        in_entry.mem_to_reg = id_mem_to_reg;
        in_entry.reg_wr     = id_reg_wr;
        in_entry.ext_op     = id_ext_op;
        in_entry.alu_src    = id_alu_src;
        in_entry.alu_ctr    = id_alu_ctr;
        in_entry.rs         = id_rs;
        in_entry.rt         = id_rt;
        in_entry.rd         = id_rd;
        in_entry.rw         = id_rw;
        in_entry.bus_a      = id_bus_a;
        in_entry.bus_b      = id_bus_b;
        in_entry.imm        = id_imm;
        in_entry.mem_read   = (id_op == LOAD_OP);
    end

`ifdef IDEX_HAZARD_DET_EN
    idex_hazard_chk u_hazard_chk (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .slot_valid ({state_q == FULL, state_q != EMPTY}),
        .main_slot  (main_q),
        .skid_slot  (skid_q),
        .hazard_c   (hazard_stall)
    );
`else
    assign hazard_stall = 1'b0;
`endif

    // Ready depends only on occupancy and the stall, never on id_valid.
    assign exe_valid = (state_q != EMPTY);
    assign id_ready  = (state_q != FULL) && !hazard_stall;
    assign accept_c  = id_valid && id_ready && !id_flush;
    assign drain_c   = exe_valid && exe_ready;

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_nx;
    end

    // Next state and slot contents; flush wins, vacated slots are zeroed.
    always_comb begin
        state_nx = state_q;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (id_flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        main_nx  = in_entry;
                        state_nx = ONE;
                    end
                end
                ONE: begin
                    if (accept_c && drain_c) begin
                        main_nx = in_entry;
                    end else if (accept_c) begin
                        skid_nx  = in_entry;
                        state_nx = FULL;
                    end else if (drain_c) begin
                        main_nx  = '0;
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    if (drain_c) begin
                        main_nx  = skid_q;
                        skid_nx  = '0;
                        state_nx = ONE;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = '0;
                    skid_nx  = '0;
                end
            endcase
        end
    end

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end

    assign exe_mem_wr     = main_q.mem_wr;
    assign exe_mem_to_reg = main_q.mem_to_reg;
    assign exe_reg_wr     = main_q.reg_wr;
    assign exe_ext_op     = main_q.ext_op;
    assign exe_alu_src    = main_q.alu_src;
    assign exe_alu_ctr    = main_q.alu_ctr;
    assign exe_rs         = main_q.rs;
    assign exe_rt         = main_q.rt;
    assign exe_rd         = main_q.rd;
    assign exe_rw         = main_q.rw;
    assign exe_bus_a      = main_q.bus_a;
    assign exe_bus_b      = main_q.bus_b;
    assign exe_imm        = main_q.imm;
    assign exe_mem_read   = main_q.mem_read;

endmodule

// File: tb/tb_idex_stage_buf.sv
// Bench for idex_stage_buf: queue-based reference model plus directed literal checks.
module tb_idex_stage_buf;
    import idex_pkg::*;

    localparam logic [5:0] LW_OP = 6'b100011;
`ifdef IDEX_HAZARD_DET_EN
    localparam logic HAZ = 1'b1;
`else
    localparam logic HAZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready, id_flush;
    logic        id_mem_wr, id_mem_to_reg, id_reg_wr, id_ext_op, id_alu_src;
    logic [2:0]  id_alu_ctr;
    logic [4:0]  id_rs, id_rt, id_rd, id_rw;
    logic [31:0] id_bus_a, id_bus_b;
    logic [15:0] id_imm;
    logic [5:0]  id_op;
    logic        exe_valid, exe_ready;
    logic        exe_mem_wr, exe_mem_to_reg, exe_reg_wr, exe_ext_op, exe_alu_src;
    logic [2:0]  exe_alu_ctr;
    logic [4:0]  exe_rs, exe_rt, exe_rd, exe_rw;
    logic [31:0] exe_bus_a, exe_bus_b;
    logic [15:0] exe_imm;
    logic        exe_mem_read, hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    idex_entry_t mq[$];

    always #5 clk = ~clk;

    idex_stage_buf dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_flush(id_flush),
        .id_mem_wr(id_mem_wr), .id_mem_to_reg(id_mem_to_reg), .id_reg_wr(id_reg_wr),
        .id_ext_op(id_ext_op), .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rw(id_rw),
        .id_bus_a(id_bus_a), .id_bus_b(id_bus_b), .id_imm(id_imm), .id_op(id_op),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_mem_wr(exe_mem_wr), .exe_mem_to_reg(exe_mem_to_reg), .exe_reg_wr(exe_reg_wr),
        .exe_ext_op(exe_ext_op), .exe_alu_src(exe_alu_src), .exe_alu_ctr(exe_alu_ctr),
        .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_rd(exe_rd), .exe_rw(exe_rw),
        .exe_bus_a(exe_bus_a), .exe_bus_b(exe_bus_b), .exe_imm(exe_imm),
        .exe_mem_read(exe_mem_read), .hazard_stall(hazard_stall)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic idex_entry_t cur_in();
        idex_entry_t e;
        e = '0;
        e.mem_wr = id_mem_wr; e.mem_to_reg = id_mem_to_reg; e.reg_wr = id_reg_wr;
        e.ext_op = id_ext_op; e.alu_src = id_alu_src; e.alu_ctr = id_alu_ctr;
        e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.rw = id_rw;
        e.bus_a = id_bus_a; e.bus_b = id_bus_b; e.imm = id_imm;
        e.mem_read = (id_op == LW_OP);
        return e;
    endfunction

    function automatic idex_entry_t dut_out();
        idex_entry_t e;
        e = '0;
        e.mem_wr = exe_mem_wr; e.mem_to_reg = exe_mem_to_reg; e.reg_wr = exe_reg_wr;
        e.ext_op = exe_ext_op; e.alu_src = exe_alu_src; e.alu_ctr = exe_alu_ctr;
        e.rs = exe_rs; e.rt = exe_rt; e.rd = exe_rd; e.rw = exe_rw;
        e.bus_a = exe_bus_a; e.bus_b = exe_bus_b; e.imm = exe_imm;
        e.mem_read = exe_mem_read;
        return e;
    endfunction

    // Model stall: presented instruction reads a register a held load will write.
    function automatic bit m_stall();
        bit s = 1'b0;
`ifdef IDEX_HAZARD_DET_EN
        foreach (mq[i])
            if (mq[i].mem_read && mq[i].rw != 5'd0 && (mq[i].rw == id_rs || mq[i].rw == id_rt))
                s = 1'b1;
        s = s && id_valid;
`endif
        return s;
    endfunction

    function automatic bit m_ready();
        return (mq.size() < 2) && !m_stall();
    endfunction

    // Reference model: a FIFO of at most two entries; flush empties it.
    always @(posedge clk or posedge rst) begin
        bit acc, drn;
        if (rst) begin
            mq.delete();
        end else if (id_flush) begin
            mq.delete();
        end else begin
            acc = id_valid && m_ready();
            drn = (mq.size() > 0) && exe_ready;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(cur_in());
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        idex_entry_t exp_e;
        if (chk_en) begin
            exp_e = '0;
            if (mq.size() > 0) exp_e = mq[0];
            chk("exe_valid", 128'(exe_valid), 128'(mq.size() > 0));
            chk("exe_entry", 128'(dut_out()), 128'(exp_e));
            chk("hazard_stall", 128'(hazard_stall), 128'(m_stall()));
            chk("id_ready", 128'(id_ready), 128'(m_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_flush = 0; id_mem_wr = 0; id_mem_to_reg = 0; id_reg_wr = 0;
        id_ext_op = 0; id_alu_src = 0; id_alu_ctr = '0; id_rs = '0; id_rt = '0;
        id_rd = '0; id_rw = '0; id_bus_a = '0; id_bus_b = '0; id_imm = '0; id_op = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        id_valid = 1'b1; id_reg_wr = 1'b1; id_bus_a = 32'h1234_5678;
        exe_ready = 1'b0;
        #1 chk_en = 1'b1;

        // Reset held with id_valid high
        @(negedge clk);
        chk("rst_exe_valid", 128'(exe_valid), 128'(0));
        chk("rst_exe_bus_a", 128'(exe_bus_a), 128'(0));
        chk("rst_exe_reg_wr", 128'(exe_reg_wr), 128'(0));
        chk("rst_id_ready", 128'(id_ready), 128'(1));
        chk("rst_hazard", 128'(hazard_stall), 128'(0));
        rst = 1'b0;
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("first_bus_a", 128'(exe_bus_a), 128'(32'h1234_5678));
        chk("first_valid", 128'(exe_valid), 128'(1));
        tick();
        exe_ready = 1'b1;
        tick();

        // Streaming eight entries at full rate
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                id_valid = 1'b1; id_bus_a = 32'(i); id_bus_b = 32'hDEAD_BEEF;
            end else begin
                id_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) chk("stream_ready", 128'(id_ready), 128'(1));
            if (i > 0) begin
                chk("stream_valid", 128'(exe_valid), 128'(1));
                chk("stream_bus_a", 128'(exe_bus_a), 128'(i - 1));
                chk("stream_bus_b", 128'(exe_bus_b), 128'(32'hDEAD_BEEF));
            end
            tick();
        end

        // Backpressure: fills after two accepts, then drains in order
        exe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_valid = 1'b1; id_bus_a = 32'(100 + i);
            @(negedge clk);
            if (i == 2) begin
                chk("full_id_ready", 128'(id_ready), 128'(0));
                chk("full_head", 128'(exe_bus_a), 128'(100));
            end
            tick();
        end
        id_valid = 1'b0; exe_ready = 1'b1;
        @(negedge clk);
        chk("drain0", 128'(exe_bus_a), 128'(100));
        tick();
        @(negedge clk);
        chk("drain1", 128'(exe_bus_a), 128'(101));
        tick();
        @(negedge clk);
        chk("drain_empty", 128'(exe_valid), 128'(0));

        // Flush while full, with an incoming entry
        exe_ready = 1'b0; id_valid = 1'b1; id_reg_wr = 1'b1;
        tick();
        tick();
        id_flush = 1'b1; id_bus_a = 32'h5555_AAAA;
        @(negedge clk);
        chk("flush_full_ready", 128'(id_ready), 128'(0));
        tick();
        id_flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 128'(exe_valid), 128'(0));
        chk("flush_reg_wr", 128'(exe_reg_wr), 128'(0));
        tick();

        // Load-use sequence
        clear_in();
        id_valid = 1'b1; id_op = LW_OP; id_rw = 5'd8; id_reg_wr = 1'b1;
        tick();
        id_op = 6'd0; id_rs = 5'd8; id_rt = 5'd3; id_rw = 5'd9;
        @(negedge clk);
        chk("lw_mem_read", 128'(exe_mem_read), 128'(1));
        chk("lw_rw", 128'(exe_rw), 128'(8));
        chk("use_stall", 128'(hazard_stall), 128'(HAZ));
        chk("use_ready", 128'(id_ready), 128'(!HAZ));
        tick();
        exe_ready = 1'b1;
        @(negedge clk);
        chk("use_stall_hold", 128'(hazard_stall), 128'(HAZ));
        chk("use_ready_hold", 128'(id_ready), 128'(0));
        tick();
        @(negedge clk);
        chk("use_stall_clear", 128'(hazard_stall), 128'(0));
        chk("use_ready_clear", 128'(id_ready), 128'(1));
`ifdef IDEX_HAZARD_DET_EN
        chk("use_bubble", 128'(exe_valid), 128'(0));
`else
        chk("use_early_rs", 128'(exe_rs), 128'(8));
        chk("use_early_mr", 128'(exe_mem_read), 128'(0));
`endif
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("use_rs", 128'(exe_rs), 128'(8));
        tick();

        // Load to r0 never stalls
        exe_ready = 1'b0; id_valid = 1'b1; id_op = LW_OP; id_rw = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        tick();
        id_op = 6'd0;
        @(negedge clk);
        chk("r0_no_stall", 128'(hazard_stall), 128'(0));
        chk("r0_ready", 128'(id_ready), 128'(1));
        tick();
        id_valid = 1'b0; exe_ready = 1'b1;
        tick();
        tick();

        // Randomised traffic with a mid-run asynchronous reset
        for (int i = 0; i < 600; i++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_flush      = ($urandom_range(0, 15) == 0);
            exe_ready     = ($urandom_range(0, 4) < 3);
            id_op         = ($urandom_range(0, 2) == 0) ? LW_OP : 6'($urandom);
            id_mem_wr     = 1'($urandom); id_mem_to_reg = 1'($urandom);
            id_reg_wr     = 1'($urandom); id_ext_op = 1'($urandom);
            id_alu_src    = 1'($urandom); id_alu_ctr = 3'($urandom);
            id_rs         = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rw         = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
            id_bus_a      = 32'($urandom); id_bus_b = 32'($urandom);
            id_imm        = 16'($urandom);
            if (i == 300) begin
                #1 rst = 1'b1;
                #1 chk("async_rst_valid", 128'(exe_valid), 128'(0));
                chk("async_rst_bus_b", 128'(exe_bus_b), 128'(0));
                rst = 1'b0;
            end
            tick();
        end

        clear_in();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_stage_buf.md
# idex_stage_buf

Parametrised ID→EXE pipeline stage buffer for the five-stage CPU: carries decoded control, operand and register-index fields from decode to execute. Adds a valid/ready handshake, a two-entry skid buffer, synchronous flush and an optional load-use hazard detector. It replaces the fixed-width, stall-by-zeroing ID/EXE register; all fields keep full width, including busB at DATA_W.

## Interface
- DATA_W, 32, operand bus width (busA, busB)
- REG_W, 5, register index width (Rs, Rt, Rd, Rw)
- IMM_W, 16, immediate width
- ALUCTR_W, 3, ALU control width
- OP_W, 6, opcode width
- LOAD_OP, 6'b100011, opcode that sets mem_read
- clk  in  1  clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  buffer can accept this cycle
- id_flush  in  1  discard all held and incoming entries (taken branch / jump)
- id_mem_wr, id_mem_to_reg, id_reg_wr, id_ext_op, id_alu_src  in  1 each  control bits
- id_alu_ctr  in  ALUCTR_W  ALU operation
- id_rs, id_rt, id_rd, id_rw  in  REG_W each  register indices
- id_bus_a, id_bus_b  in  DATA_W each  operands
- id_imm  in  IMM_W  immediate
- id_op  in  OP_W  opcode
- exe_valid  out  1  EXE entry valid
- exe_ready  in  1  EXE consumes the entry
- exe_* (same fields as id_*, minus op)  out  matching widths  registered fields
- exe_mem_read  out  1  entry is a load (id_op == LOAD_OP at capture)
- hazard_stall  out  1  load-use stall request (0 when feature compiled out)

## Operation
- Entry = all id_* fields plus derived mem_read; two slots: MAIN (drives exe_*) and SKID.
- States: EMPTY, ONE (MAIN valid), FULL (MAIN+SKID valid). exe_valid = state != EMPTY; id_ready = (state != FULL) && !hazard_stall.
- Accept = id_valid && id_ready && !id_flush. Drain = exe_valid && exe_ready.
- EMPTY: accept → MAIN, go ONE.
- ONE: accept && drain → MAIN overwritten, stay ONE; accept only → SKID, go FULL; drain only → EMPTY.
- FULL: drain → SKID moves to MAIN, go ONE; no accept possible.
- id_flush: next state EMPTY, both slots invalidated, incoming entry dropped; flush beats accept and drain.
- Invalid slots: all exe_* outputs driven 0 (bubble is all-zero, RegWr/MemWr 0).
- Order preserved; no entry is duplicated or lost absent flush.

## Timing
- Latency: accepted entry appears on exe_* the next rising edge when buffer was EMPTY or drained same cycle.
- id_ready is combinational from state and hazard_stall only; never from id_valid (no loop).
- Throughput: one entry per cycle with exe_ready held 1.
- exe_* stable while exe_valid && !exe_ready (no change until drain or flush).
- Reset (async assert, sync-safe deassert handled upstream): state EMPTY, all exe_* 0, exe_valid 0, exe_mem_read 0, hazard_stall 0, id_ready 1.
- Reset mid-transfer discards both slots immediately.

## Configuration
- IDEX_HAZARD_DET_EN defined: hazard_stall = id_valid && ∃ valid slot with mem_read && slot rw != 0 && slot rw ∈ {id_rs, id_rt}; asserting it deasserts id_ready combinationally. Clears once the load leaves both slots.
- Undefined: hazard_stall tied 0; detection left to the external hazard unit.

## Structure
- Shared package idex_pkg: idex_entry_t packed struct (all fields + mem_read), state enum {EMPTY, ONE, FULL}, LOAD_OP default constant.
- One sub-module natural: idex_hazard_chk (combinational compare of id_rs/id_rt against slot fields), instantiated only under IDEX_HAZARD_DET_EN.

## Test plan
- Reset with id_valid=1 → exe_valid 0, all exe_* 0, id_ready 1; release, next edge entry with id_bus_a=32'h1234_5678 appears on exe_bus_a.
- Streaming 8 entries, exe_ready=1 → one per cycle, in order, exe_bus_b full 32-bit value 32'hDEAD_BEEF intact.
- exe_ready=0 for 3 cycles with id_valid=1 → buffer reaches FULL after 2 accepts, id_ready 0; on exe_ready=1 entries drain in order, none lost.
- id_flush in FULL with id_valid=1 → next edge exe_valid 0, exe_reg_wr 0, incoming entry dropped.
- Hazard enabled: lw (id_op=6'b100011, rw=5'd8) accepted, next instr id_rs=5'd8 → hazard_stall 1, id_ready 0 until lw drains; id_rs=5'd0 against rw=0 → no stall.
- Macro undefined: same lw/use sequence → hazard_stall stays 0, dependent entry accepted next cycle.
